// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO that buffers CPU writes in front of the UART
// transmitter. It exposes a valid/ready head port for the transmitter and
// full, occupancy and sticky overflow status for software polling.
module uart_tx_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clr_overflow,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Storage and pointers. Pointers carry one extra bit so that full and
  // empty can be told apart when the low (index) bits are equal.
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2:0]   wp_q, wp_d;
  logic [DEPTH_LOG2:0]   rp_q, rp_d;
  logic                  overflow_q, overflow_d;

  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Status flags, all derived from registered pointers only.
  assign empty     = (wp_q == rp_q);
  assign full      = (wp_q[DEPTH_LOG2-1:0] == rp_q[DEPTH_LOG2-1:0]) &&
                     (wp_q[DEPTH_LOG2] != rp_q[DEPTH_LOG2]);
  assign count     = wp_q - rp_q;
  assign out_valid = !empty;
  assign overflow  = overflow_q;

  // Head byte is a plain combinational read at the read pointer.
  assign out_data  = mem_q[rp_q[DEPTH_LOG2-1:0]];

  // A push while full is dropped even if a pop frees a slot this cycle.
  assign push = wr_en && !full;
  assign drop = wr_en && full;
  assign pop  = out_valid && out_ready;

  // Next-state for pointers and the sticky overflow flag.
  // NOTE: combinational blocks use blocking '=' with a default assignment
  // first, so every path assigns every output and no latch is inferred.
  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    overflow_d = overflow_q;
    if (push) wp_d = wp_q + 1'b1;
    if (pop)  rp_d = rp_q + 1'b1;
    // A dropped push in the same cycle as a clear keeps the flag set.
    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  // Pointer and flag registers; reset wins over any push, pop or clear.
  // NOTE: sequential state is updated with non-blocking '<=' so all
  // registers see the pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wp_q       <= '0;
      rp_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte array write port.
  // NOTE: the array is deliberately not reset; empty pointers make stale
  // contents unobservable, and leaving it unreset lets it map to RAM.
  always_ff @(posedge CLK) begin
    if (push && !RST) mem_q[wp_q[DEPTH_LOG2-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: directed scenarios plus random
// streaming, with a queue-based reference model and a scoreboard monitor.
module tb_uart_tx_queue;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int COUNT_MAX  = 3;
  localparam int FRAME_CYC  = 10 * (COUNT_MAX + 1);

  logic                CLK = 1'b0;
  logic                RST;
  logic [7:0]          wr_data;
  logic                wr_en;
  logic                full;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                clr_overflow;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_ready;

  uart_tx_queue #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // Reference model: occupancy and sticky flag, plus a scoreboard queue of
  // accepted bytes in arrival order. Updated at negedge, when inputs for the
  // coming edge are stable.
  logic [7:0] sb[$];
  int         model_count = 0;
  bit         model_ovf   = 1'b0;
  bit         model_init  = 1'b0;
  int         total_push  = 0;

  always @(negedge CLK) begin
    bit m_full;
    bit m_pop;
    bit m_push;
    if (model_init) begin
      check("count",     int'(count),     model_count);
      check("full",      int'(full),      int'(model_count == DEPTH));
      check("out_valid", int'(out_valid), int'(model_count != 0));
      check("overflow",  int'(overflow),  int'(model_ovf));
    end
    if (RST) begin
      model_count = 0;
      model_ovf   = 1'b0;
      total_push  = 0;
      sb.delete();
      model_init  = 1'b1;
    end else if (model_init) begin
      m_full = (model_count == DEPTH);
      m_pop  = (model_count != 0) && out_ready;
      m_push = wr_en && !m_full;
      if (wr_en && m_full)   model_ovf = 1'b1;
      else if (clr_overflow) model_ovf = 1'b0;
      if (m_push) begin
        sb.push_back(wr_data);
        total_push++;
      end
      model_count = model_count + int'(m_push) - int'(m_pop);
    end
  end

  // Monitor: whenever the head is presented, it must be the oldest accepted
  // byte; a handshake retires that byte from the scoreboard.
  always @(negedge CLK) begin
    if (model_init && !RST && out_valid) begin
      if (sb.size() == 0) begin
        check("head_without_entry", 1, 0);
      end else begin
        check("out_data", int'(out_data), int'(sb[0]));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus: inputs applied after an edge, handshake sampled
  // mid-cycle, returns just after the next edge.
  bit       last_pop;
  logic [7:0] last_data;

  task automatic cycle(input logic wr, input logic [7:0] d, input logic rdy,
                       input logic clr, input logic rst);
    wr_en        = wr;
    wr_data      = d;
    out_ready    = rdy;
    clr_overflow = clr;
    RST          = rst;
    @(negedge CLK);
    last_pop  = out_valid && out_ready && !RST;
    last_data = out_data;
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while (model_count != 0 && guard < 200) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    check("drain_timeout", int'(model_count != 0), 0);
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] got[$];
    logic [7:0] abc[3];
    int         frame_left;
    int         guard;
    int         pushed;
    logic       w;

    abc[0] = 8'h41; abc[1] = 8'h42; abc[2] = 8'h43;

    // Reset
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("rst_valid", int'(out_valid), 0);
    check("rst_count", int'(count),     0);
    check("rst_full",  int'(full),      0);
    check("rst_ovf",   int'(overflow),  0);

    // 1: single push, head held while not ready
    cycle(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("t1_valid", int'(out_valid), 1);
      check("t1_data",  int'(out_data),  8'h41);
      check("t1_count", int'(count),     1);
      idle();
    end
    drain();

    // 2: fill to capacity, drop one, drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    check("t2_full",  int'(full),  1);
    check("t2_count", int'(count), DEPTH);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    check("t2_ovf",       int'(overflow), 1);
    check("t2_count_ovf", int'(count),    DEPTH);
    got.delete();
    guard = 0;
    while (model_count != 0 && guard < 100) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      if (last_pop) got.push_back(last_data);
      guard++;
    end
    check("t2_drain_len", got.size(), DEPTH);
    for (int i = 0; i < got.size(); i++) check("t2_order", int'(got[i]), i);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // 3: push and pop while full, clear collisions
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    check("t3_count", int'(count),    DEPTH - 1);
    check("t3_ovf",   int'(overflow), 1);
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    check("t3_refull", int'(full), 1);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    check("t3_clr_vs_drop", int'(overflow), 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("t3_clr", int'(overflow), 0);
    drain();

    // 4: transmitter-paced draining of "ABC"
    for (int i = 0; i < 3; i++) cycle(1'b1, abc[i], 1'b0, 1'b0, 1'b0);
    check("t4_count3", int'(count), 3);
    got.delete();
    frame_left = 0;
    guard      = 0;
    while (got.size() < 3 && guard < 400) begin
      cycle(1'b0, 8'h00, frame_left == 0, 1'b0, 1'b0);
      if (last_pop) begin
        got.push_back(last_data);
        check("t4_count_step", int'(count), 3 - got.size());
        frame_left = FRAME_CYC;
      end else if (frame_left > 0) begin
        frame_left--;
      end
      guard++;
    end
    check("t4_bytes", got.size(), 3);
    for (int i = 0; i < got.size(); i++) check("t4_byte", int'(got[i]), int'(abc[i]));

    // 5: random streaming across several pointer wraps
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    pushed = 0;
    guard  = 0;
    while (pushed < 100 && guard < 3000) begin
      w = ($urandom_range(0, 3) != 0) && (model_count < DEPTH);
      cycle(w, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (w) pushed++;
      guard++;
    end
    check("t5_pushed", pushed, 100);
    drain();
    check("t5_wraps", int'(total_push >= 3 * 2 * DEPTH), 1);

    // 6: reset wins over push, pop and pending contents
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    check("t6_count5", int'(count), 5);
    cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
    check("t6_count", int'(count),     0);
    check("t6_valid", int'(out_valid), 0);
    check("t6_ovf",   int'(overflow),  0);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    check("t6_push_valid", int'(out_valid), 1);
    check("t6_push_data",  int'(out_data),  8'h5A);
    drain();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte FIFO sitting directly upstream of the UART transmitter. The CPU I/O path pushes bytes at core speed; the queue presents them one at a time to the transmitter's `in`/`valid`/`ready` handshake and absorbs bursts while the serial line runs at baud rate. It provides full, occupancy and sticky overflow status for software polling.

## Interface

- `DEPTH_LOG2`, default 4: log2 of capacity, so the default capacity is 16 bytes; legal range 1..10.
- `CLK`  in  1  system clock; all state updates on posedge.
- `RST`  in  1  reset, synchronous, active-high.
- `wr_data`  in  8  byte to enqueue.
- `wr_en`  in  1  push request, sampled each cycle.
- `full`  out  1  queue holds 2^DEPTH_LOG2 entries.
- `count`  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
- `overflow`  out  1  sticky flag: a push was dropped.
- `clr_overflow`  in  1  clears `overflow`.
- `out_data`  out  8  head byte; connects to the transmitter's `in`.
- `out_valid`  out  1  queue non-empty; connects to the transmitter's `valid`.
- `out_ready`  in  1  consumer accepts; connects to the transmitter's `ready`.

## Operation

- Storage: 2^DEPTH_LOG2 × 8-bit array. Write and read pointers are DEPTH_LOG2+1 bits wide and wrap modulo 2^(DEPTH_LOG2+1).
  - Array index is the low DEPTH_LOG2 bits of each pointer.
  - `count` = wp − rp, modulo 2^(DEPTH_LOG2+1).
  - empty: wp == rp. full: the low bits are equal and the MSBs differ.
- Push: when `wr_en && !full`, store `wr_data` at wp and increment wp.
- Dropped push: when `wr_en && full`, nothing is stored and `overflow` is set to 1.
  - `full` is the registered state at the start of the cycle. A push while full is dropped even if a pop happens in the same cycle.
- Pop: when `out_valid && out_ready`, increment rp. Data is not cleared.
- `out_valid` = !empty. `out_data` is a combinational read of the array at rp.
  - Stable while `out_valid` is high and no pop occurs.
  - Don't-care while empty.
- Simultaneous push and pop (not full): both happen and `count` is unchanged.
- Push while empty: no pop can occur that cycle, because `out_valid` was 0.
- Overflow flag:
  - `clr_overflow` clears it.
  - A dropped push in the same cycle as `clr_overflow` wins: the flag stays 1.
- Transmitter coupling: the transmitter's `ready` falls the cycle after acceptance and stays low for the whole frame. The queue therefore pops at most one byte per frame. No extra logic is needed.
- Reset (synchronous, `RST` high at posedge):
  - wp = rp = 0 and `overflow` = 0; contents are discarded.
  - Takes priority over any push, pop or clear in the same cycle.
  - A frame already in progress in the transmitter is unaffected. After reset, `out_valid` stays low until the next push.

## Timing

- Reset values: `out_valid`=0, `full`=0, `count`=0, `overflow`=0. `out_data` is undefined.
- Push latency: a push at edge N makes `out_valid`=1 and `out_data` equal to that byte in the cycle after edge N.
- `count`, `full` and `out_valid` all reflect the state after the most recent edge. They are derived from registers with no combinational path from `wr_en`.
- `out_valid` depends only on registers, never combinationally on `out_ready`.
- Throughput: 1 push plus 1 pop per cycle, sustained.
- Pointer wrap: after 2^(DEPTH_LOG2+1) pushes and pops, the pointers return to 0 with correct `count`. The bench must exercise this.

## Test plan

1. Reset, then push 0x41 at a cycle; no pop. → Next cycle: `out_valid`=1, `out_data`=0x41, `count`=1. Hold `out_ready`=0 for 10 cycles → all three outputs unchanged.
2. Push 0x00..0x0F back to back with `out_ready`=0 (DEPTH_LOG2=4). → `full`=1 and `count`=16. A 17th push of 0xFF → `overflow`=1 and `count` stays 16. Drain → bytes come out 0x00..0x0F in order, with no 0xFF.
3. With `full`=1, assert `wr_en` and `out_ready` in the same cycle. → Pop occurs, push is dropped, `count`=15, `overflow`=1. Assert `clr_overflow` together with another dropped push → `overflow` stays 1. `clr_overflow` alone → 0.
4. Connect to the transmitter (`COUNT_MAX`=3) and push "ABC". → The serial line shows three 10-bit frames (0x41, 0x42, 0x43, LSB first). Each pop occurs only on a `ready` cycle, and `count` steps 3→2→1→0.
5. Stream 100 bytes with random `wr_en` and random `out_ready` (not full). → Output sequence equals input sequence, `count` always matches a model, and the pointers wrap at least 3 times.
6. Fill 5 entries, then assert `RST` together with `wr_en` and `out_ready`. → Next cycle: `count`=0, `out_valid`=0, `overflow`=0. A following push works normally.
